// File: rtl/config_shift_ctrl.sv
// config_shift_ctrl: takes bitstream words over valid/ready and shifts them MSB-first
// into the fabric configuration chain, stopping after exactly CONFIG_WIDTH bits.
module config_shift_ctrl #(
   parameter int CONFIG_WIDTH = 64,
   parameter int WORD_WIDTH   = 32,
   localparam int CW          = $clog2(CONFIG_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  config_in,
   output logic                  config_en,
   output logic                  busy,
   output logic                  config_done,
   output logic [CW-1:0]         bit_count
);

   localparam int WL                  = $clog2(WORD_WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(CONFIG_WIDTH - 1);
   localparam logic [WL-1:0] WORD_LST = WL'(WORD_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [WORD_WIDTH-1:0] r_shift;
   logic [WL-1:0]         r_word_left;
   logic                  r_config_in;
   logic                  r_config_en;
   logic [CW-1:0]         r_bit_count;
   logic                  r_config_done;

   state_t                w_state_nxt;
   logic [WORD_WIDTH-1:0] w_shift_nxt;
   logic [WL-1:0]         w_word_left_nxt;
   logic                  w_config_in_nxt;
   logic                  w_config_en_nxt;
   logic [CW-1:0]         w_bit_count_nxt;
   logic                  w_done_nxt;

   logic                  w_last_bit;
   logic                  w_final_bit;
   logic                  w_more_bits;
   logic                  w_ready;
   logic                  w_accept;

   // r_word_left counts the bits of the current word still to follow the one on config_in
   always_comb begin
      w_last_bit  = (r_state == S_SHIFT) && (r_word_left == '0);
      w_final_bit = (r_state == S_SHIFT) && (r_bit_count == LAST_CNT);
      w_more_bits = (r_bit_count < LAST_CNT);
      w_ready     = (r_state == S_LOAD) || (w_last_bit && w_more_bits);
      w_accept    = word_valid && w_ready;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_word_left_nxt = r_word_left;
      w_config_in_nxt = r_config_in;
      w_config_en_nxt = 1'b0;
      w_bit_count_nxt = r_bit_count;
      w_done_nxt      = r_config_done;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt     = S_LOAD;
               w_done_nxt      = 1'b0;
               w_bit_count_nxt = '0;
            end
         end

         S_LOAD: begin
            if (w_accept) begin
               w_state_nxt     = S_SHIFT;
               w_config_in_nxt = word_data[WORD_WIDTH-1];
               w_shift_nxt     = {word_data[WORD_WIDTH-2:0], 1'b0};
               w_word_left_nxt = WORD_LST;
               w_config_en_nxt = 1'b1;
            end
         end

         S_SHIFT: begin
            w_bit_count_nxt = r_bit_count + 1'b1;
            // The chain length check wins over the word boundary so a partial last word stops mid-word
            if (w_final_bit) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
            end else if (w_last_bit) begin
               if (w_accept) begin
                  w_config_in_nxt = word_data[WORD_WIDTH-1];
                  w_shift_nxt     = {word_data[WORD_WIDTH-2:0], 1'b0};
                  w_word_left_nxt = WORD_LST;
                  w_config_en_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_LOAD;
               end
            end else begin
               w_config_in_nxt = r_shift[WORD_WIDTH-1];
               w_shift_nxt     = r_shift << 1;
               w_word_left_nxt = r_word_left - 1'b1;
               w_config_en_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_shift       <= '0;
         r_word_left   <= '0;
         r_config_in   <= 1'b0;
         r_config_en   <= 1'b0;
         r_bit_count   <= '0;
         r_config_done <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_shift       <= w_shift_nxt;
         r_word_left   <= w_word_left_nxt;
         r_config_in   <= w_config_in_nxt;
         r_config_en   <= w_config_en_nxt;
         r_bit_count   <= w_bit_count_nxt;
         r_config_done <= w_done_nxt;
      end
   end

   assign word_ready  = w_ready;
   assign config_in   = r_config_in;
   assign config_en   = r_config_en;
   assign busy        = (r_state == S_LOAD) || (r_state == S_SHIFT);
   assign config_done = r_config_done;
   assign bit_count   = r_bit_count;

endmodule

// File: tb/tb_config_shift_ctrl.sv
// Bench for config_shift_ctrl: three chain/word geometries, randomized word streams and
// valid gaps, scoreboarded against a timing model built from the handshake rules.
module tb_config_shift_ctrl;

   typedef struct {
      int cyc;
      bit b;
      int cnt;
   } exp_t;

   logic clk;
   int   cyc     = 0;
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_done  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input int inst, input bit ok, input string nm,
                        input longint act, input longint exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL [inst %0d] %s: got %0h expected %0h", inst, nm, act, exp);
   endtask

   for (genvar k = 0; k < 3; k++) begin : g_inst
      localparam int CWL   = (k == 0) ? 64 : (k == 1) ? 40 : 1;
      localparam int WWL   = (k == 0) ? 32 : (k == 1) ? 16 : 2;
      localparam int NWL   = (CWL + WWL - 1) / WWL;
      localparam int CWB   = $clog2(CWL + 1);
      localparam int NLOAD = 10;
      localparam int VP    = 512;

      logic           rst, start, wv, wr, cin, cen, busy, cdone;
      logic [WWL-1:0] wd;
      logic [CWB-1:0] bc;

      config_shift_ctrl #(.CONFIG_WIDTH(CWL), .WORD_WIDTH(WWL)) u_dut (
         .clk        (clk),
         .reset      (rst),
         .start      (start),
         .word_data  (wd),
         .word_valid (wv),
         .word_ready (wr),
         .config_in  (cin),
         .config_en  (cen),
         .busy       (busy),
         .config_done(cdone),
         .bit_count  (bc)
      );

      exp_t        eq[$];
      int          dq[$];
      bit          vpat[VP];
      logic [31:0] wds[NWL];
      int          a[NWL];
      int          bitcyc[CWL];
      int          S, D, rr, nb, idx, sp, rab, mode;
      bit          ab, aborted;
      exp_t        e;

      // monitor: every config_en cycle must match the next expected bit, in time and value
      int   acc_cnt;
      bit   prev_done;
      exp_t me;
      int   dcyc;
      initial begin
         acc_cnt   = 0;
         prev_done = 0;
         forever begin
            @(negedge clk);
            if (rst) begin
               acc_cnt   = 0;
               prev_done = 0;
            end else begin
               if (wv && wr) acc_cnt++;
               if (cen) begin
                  check(k, eq.size() > 0, "extra_config_en", cyc, 0);
                  if (eq.size() > 0) begin
                     me = eq.pop_front();
                     check(k, cyc == me.cyc, "bit_cycle", cyc, me.cyc);
                     check(k, cin == me.b, "config_in", cin, me.b);
                     check(k, int'(bc) == me.cnt, "bit_count", bc, me.cnt);
                     check(k, busy == 1'b1, "busy_shift", busy, 1);
                  end
               end
               if (cdone && !prev_done) begin
                  check(k, dq.size() > 0, "unexpected_done", cyc, 0);
                  if (dq.size() > 0) begin
                     dcyc = dq.pop_front();
                     check(k, cyc == dcyc, "done_cycle", cyc, dcyc);
                     check(k, acc_cnt == NWL, "words_accepted", acc_cnt, NWL);
                     check(k, int'(bc) == CWL, "done_count", bc, CWL);
                     check(k, busy == 1'b0, "busy_done", busy, 0);
                  end
                  acc_cnt = 0;
               end
               prev_done = cdone;
            end
         end
      end

      initial begin : stim
         rst   = 1'b1;
         start = 1'b0;
         wv    = 1'b0;
         wd    = '0;
         repeat (3) @(posedge clk);
         #1;
         check(k, {wr, cin, cen, busy, cdone} == 5'b0 && bc == '0, "reset_state",
               {wr, cin, cen, busy, cdone, bc}, 0);
         rst = 1'b0;

         for (int L = 0; L < NLOAD; L++) begin
            mode = (L == 0) ? 0 : (L == 1 && NWL >= 2) ? 1 : 2;
            for (int r = 0; r < VP; r++)
               vpat[r] = (r >= 256 || mode != 2) ? 1'b1 : ($urandom_range(3, 0) != 0);
            if (mode == 1)
               for (int r = 1 + WWL; r < 6 + WWL; r++) vpat[r] = 1'b0;

            for (int i = 0; i < NWL; i++) wds[i] = $urandom;
            if (k == 0 && L < 2) begin
               wds[0] = 32'hDEADBEEF;
               wds[1] = 32'h12345678;
            end else if (k == 0 && L == 2) begin
               wds[0] = 32'h00000000;
               wds[1] = 32'hFFFFFFFF;
            end else if (k == 1 && L == 0) begin
               wds[0] = 32'h0000A5A5;
               wds[1] = 32'h0000FFFF;
               wds[2] = 32'h00003CFF;
            end else if (k == 2 && L == 0) begin
               wds[0] = 32'h00000002;
            end

            @(posedge clk);
            #1;
            S = cyc;
            // a word is taken on the first valid cycle at or after its request cycle
            rr = 1;
            for (int i = 0; i < NWL; i++) begin
               while (!vpat[rr]) rr++;
               a[i] = rr;
               nb   = (CWL - i * WWL < WWL) ? CWL - i * WWL : WWL;
               for (int j = 0; j < nb; j++) begin
                  e.cyc = S + rr + 1 + j;
                  e.b   = wds[i][WWL-1-j];
                  e.cnt = i * WWL + j;
                  eq.push_back(e);
                  bitcyc[e.cnt] = rr + 1 + j;
               end
               rr = rr + nb;
            end
            D = rr + 1;
            dq.push_back(S + D);

            sp  = (L == 2 || (L >= 3 && $urandom_range(1, 0) == 1)) ? $urandom_range(D - 1, 1) : 0;
            ab  = (CWL >= 18) && (L == 3 || L == 6);
            rab = ab ? bitcyc[(L == 3) ? 17 : $urandom_range(CWL - 1, 0)] : 0;
            aborted = 1'b0;

            start = 1'b1;
            wv    = 1'($urandom_range(1, 0));
            wd    = WWL'($urandom);

            for (int r = 1; r <= D; r++) begin
               @(posedge clk);
               #1;
               if (r == 1) begin
                  check(k, cdone == 1'b0 && busy == 1'b1 && cen == 1'b0, "start_state",
                        {cdone, busy, cen}, 3'b010);
                  check(k, bc == '0, "start_count", bc, 0);
               end
               idx = 0;
               for (int i = 0; i < NWL; i++) if (a[i] < r) idx++;
               start = (r == sp);
               wv    = vpat[r];
               wd    = (idx < NWL) ? wds[idx][WWL-1:0] : WWL'($urandom);
               if (ab && r == rab) begin
                  @(negedge clk);
                  #1;
                  rst = 1'b1;
                  #1;
                  check(k, {wr, cin, cen, busy, cdone} == 5'b0 && bc == '0, "async_reset",
                        {wr, cin, cen, busy, cdone, bc}, 0);
                  eq.delete();
                  dq.delete();
                  repeat (2) @(posedge clk);
                  #1;
                  rst     = 1'b0;
                  start   = 1'b0;
                  wv      = 1'b0;
                  aborted = 1'b1;
                  break;
               end
            end

            if (!aborted) begin
               repeat (1 + $urandom_range(2, 0)) begin
                  @(posedge clk);
                  #1;
                  start = 1'b0;
                  wv    = 1'($urandom_range(1, 0));
                  wd    = WWL'($urandom);
               end
               check(k, cdone == 1'b1 && int'(bc) == CWL, "done_hold", {cdone, bc}, {1'b1, CWB'(CWL)});
            end
         end

         repeat (4) @(posedge clk);
         #1;
         check(k, eq.size() == 0 && dq.size() == 0, "queue_drained", eq.size() + dq.size(), 0);
         n_done++;
      end
   end

   initial begin
      for (int c = 0; c < 60000 && n_done < 3; c++) @(posedge clk);
      check(-1, n_done == 3, "all_instances_finished", n_done, 3);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
